switch_mcast_fifo: RTL

- Next-generation packet switch: learned address table, input packet FIFO, unicast and broadcast delivery, per-packet delivery timeout.
- Packets enter through a ready/valid interface and are queued.
- Each packet is looked up and driven onto one or more output lanes until every targeted port acknowledges or the timeout expires.
- One completion pulse with status is produced per packet.

---
 rtl/switch_mcast_fifo.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/switch_mcast_fifo.sv
// Packet switch: learned address table, input packet FIFO, unicast/broadcast
// delivery on per-port lanes with a per-packet timeout and completion status.
module switch_mcast_fifo #(
  parameter int NUM_OF_PORTS     = 10,
  parameter int PORT_ADDR_LENGTH = 8,
  parameter int DATA_WIDTH       = 8,
  parameter int FIFO_DEPTH       = 4,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               mem_write,
  input  logic [$clog2(NUM_OF_PORTS)-1:0]    mem_port_index,
  input  logic [PORT_ADDR_LENGTH-1:0]        mem_address,
  input  logic                               pkt_valid,
  output logic                               pkt_ready,
  input  logic [PORT_ADDR_LENGTH-1:0]        pkt_address,
  input  logic [DATA_WIDTH-1:0]              pkt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               packet_finished,
  output logic [1:0]                         packet_status,
  output logic [NUM_OF_PORTS-1:0]            port_req,
  output logic [NUM_OF_PORTS*DATA_WIDTH-1:0] port_data,
  input  logic [NUM_OF_PORTS-1:0]            port_received
);

  localparam int IDX_W = $clog2(NUM_OF_PORTS);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
  localparam int LW    = NUM_OF_PORTS * DATA_WIDTH;

  localparam logic [PORT_ADDR_LENGTH-1:0] BCAST_ADDR  = {PORT_ADDR_LENGTH{1'b1}};
  localparam logic [IDX_W:0]              NUM_PORTS_L = (IDX_W+1)'(NUM_OF_PORTS);
  localparam logic [CNT_W-1:0]            DEPTH_L     = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0]            PTR_LAST    = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [TMR_W-1:0]            TMR_LAST    = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] STAT_OK      = 2'b00;
  localparam logic [1:0] STAT_MISS    = 2'b01;
  localparam logic [1:0] STAT_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_SEND   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  logic [NUM_OF_PORTS-1:0]     tbl_valid_r;
  logic [PORT_ADDR_LENGTH-1:0] tbl_addr_r [NUM_OF_PORTS];
  logic [NUM_OF_PORTS-1:0]     dup_s;
  logic                        wr_ok_s;

  logic [PORT_ADDR_LENGTH-1:0] fifo_addr_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]       fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_r;
  logic [PTR_W-1:0]            rd_ptr_r;
  logic [CNT_W-1:0]            fifo_count_r;
  logic [CNT_W-1:0]            cnt_nxt_s;
  logic                        ready_r;
  logic                        push_s;
  logic                        pop_s;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [PORT_ADDR_LENGTH-1:0] hold_addr_r;
  logic [DATA_WIDTH-1:0]       hold_data_r;
  logic [NUM_OF_PORTS-1:0]     hit_s;
  logic [NUM_OF_PORTS-1:0]     mask_s;
  logic [NUM_OF_PORTS-1:0]     left_s;
  logic [NUM_OF_PORTS-1:0]     pending_r;
  logic [NUM_OF_PORTS-1:0]     pending_nxt_s;
  logic [TMR_W-1:0]            timer_r;
  logic [TMR_W-1:0]            timer_nxt_s;
  logic [1:0]                  status_r;
  logic [1:0]                  status_nxt_s;
  logic                        finished_r;
  logic [LW-1:0]               port_data_r;
  logic [LW-1:0]               port_data_nxt_s;

  // A write is dropped when the index is out of range, the address is the
  // broadcast value, or the address is already owned by another entry.
  always_comb begin
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      dup_s[i] = tbl_valid_r[i] && (tbl_addr_r[i] == mem_address) &&
                 (IDX_W'(i) != mem_port_index);
    end
    wr_ok_s = mem_write && ({1'b0, mem_port_index} < NUM_PORTS_L) &&
              (mem_address != BCAST_ADDR) && !(|dup_s);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tbl_valid_r <= {NUM_OF_PORTS{1'b0}};
      for (int i = 0; i < NUM_OF_PORTS; i++) begin
        tbl_addr_r[i] <= {PORT_ADDR_LENGTH{1'b0}};
      end
    end else if (wr_ok_s) begin
      tbl_valid_r[mem_port_index] <= 1'b1;
      tbl_addr_r[mem_port_index]  <= mem_address;
    end
  end

  assign push_s = pkt_valid && ready_r;

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = fifo_count_r + CNT_W'(1);
      2'b01:   cnt_nxt_s = fifo_count_r - CNT_W'(1);
      default: cnt_nxt_s = fifo_count_r;
    endcase
  end

  // Ready is registered from the next count so a full queue never accepts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      fifo_count_r <= {CNT_W{1'b0}};
      ready_r      <= 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= {PORT_ADDR_LENGTH{1'b0}};
        fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= pkt_address;
        fifo_data_r[wr_ptr_r] <= pkt_data;
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      fifo_count_r <= cnt_nxt_s;
      ready_r      <= (cnt_nxt_s < DEPTH_L);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      hit_s[i] = tbl_valid_r[i] && (tbl_addr_r[i] == hold_addr_r);
    end
  end

  assign mask_s = (hold_addr_r == BCAST_ADDR) ? tbl_valid_r : hit_s;
  assign left_s = pending_r & ~port_received;

  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    timer_nxt_s   = timer_r;
    status_nxt_s  = status_r;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fifo_count_r != {CNT_W{1'b0}}) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_LOOKUP;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (mask_s == {NUM_OF_PORTS{1'b0}}) begin
          status_nxt_s = STAT_MISS;
          state_nxt_s  = ST_DONE;
        end else begin
          pending_nxt_s = mask_s;
          timer_nxt_s   = {TMR_W{1'b0}};
          state_nxt_s   = ST_SEND;
        end
      end
      ST_SEND: begin
        if (left_s == {NUM_OF_PORTS{1'b0}}) begin
          pending_nxt_s = {NUM_OF_PORTS{1'b0}};
          status_nxt_s  = STAT_OK;
          state_nxt_s   = ST_DONE;
        end else if (timer_r == TMR_LAST) begin
          pending_nxt_s = {NUM_OF_PORTS{1'b0}};
          status_nxt_s  = STAT_TIMEOUT;
          state_nxt_s   = ST_DONE;
        end else begin
          pending_nxt_s = left_s;
          timer_nxt_s   = timer_r + TMR_W'(1);
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        pending_nxt_s = {NUM_OF_PORTS{1'b0}};
        state_nxt_s   = ST_IDLE;
      end
    endcase
  end

  // Lane data is registered from the next pending mask so it lines up with port_req.
  always_comb begin
    port_data_nxt_s = {LW{1'b0}};
    for (int i = 0; i < NUM_OF_PORTS; i++) begin
      if (pending_nxt_s[i]) begin
        port_data_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] = hold_data_r;
      end else begin
        port_data_nxt_s[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      hold_addr_r <= {PORT_ADDR_LENGTH{1'b0}};
      hold_data_r <= {DATA_WIDTH{1'b0}};
      pending_r   <= {NUM_OF_PORTS{1'b0}};
      timer_r     <= {TMR_W{1'b0}};
      status_r    <= STAT_OK;
      finished_r  <= 1'b0;
      port_data_r <= {LW{1'b0}};
    end else begin
      if (pop_s) begin
        hold_addr_r <= fifo_addr_r[rd_ptr_r];
        hold_data_r <= fifo_data_r[rd_ptr_r];
      end
      state_r     <= state_nxt_s;
      pending_r   <= pending_nxt_s;
      timer_r     <= timer_nxt_s;
      status_r    <= status_nxt_s;
      finished_r  <= (state_nxt_s == ST_DONE);
      port_data_r <= port_data_nxt_s;
    end
  end

  assign pkt_ready       = ready_r;
  assign fifo_count      = fifo_count_r;
  assign packet_finished = finished_r;
  assign packet_status   = status_r;
  assign port_req        = pending_r;
  assign port_data       = port_data_r;

endmodule
